// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
//
// Purpose:
//   Consumes the registered adder's SUM_WIDTH-bit result stream.
//   BLOCK_LEN consecutive accepted sums are added into a wider accumulator.
//   The block total is then presented on a valid/ready output port.
//   The input is stalled while a finished total waits to be taken.
//
// Handshake semantics (both ports):
//   - A word moves on a rising clk edge where valid and ready are both 1.
//   - Neither side may make valid depend combinationally on ready.
//   - sum_ready is a registered output.
//   - While acc_valid is 1, acc_out is stable until the output transfer.
//
// Ports:
//   clk          in   clock; all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   sum_in       in   [SUM_WIDTH-1:0] sum word from the adder stage
//   sum_valid    in   sum_in is valid this cycle
//   sum_ready    out  block accepts sum_in this cycle (registered)
//   acc_out      out  [ACC_WIDTH-1:0] completed block total
//   acc_valid    out  acc_out holds a completed total
//   acc_ready    in   sink takes acc_out this cycle
//   blocks_done  out  [CNT_WIDTH-1:0] totals handed off, wraps modulo 2^CNT_WIDTH
//   acc_sat      out  (only with ACC_SATURATE_EN) block total was clamped
//
// Build option:
//   ACC_SATURATE_EN
//     Defined:
//       - Each add is computed one bit wider than the accumulator.
//       - On carry-out the accumulator clamps to all-ones.
//       - The clamp is reported per block on acc_sat.
//     Undefined:
//       - Additions wrap modulo 2^ACC_WIDTH.
//       - The acc_sat port does not exist.
//
// FSM state is held in the signal `state`, which checkers can reference
// hierarchically.

module adder_sum_accumulator #(
  parameter int SUM_WIDTH = 149,
  parameter int ACC_WIDTH = 165,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SUM_WIDTH-1:0] sum_in,
  input  logic                 sum_valid,
  output logic                 sum_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 acc_valid,
  input  logic                 acc_ready,
`ifdef ACC_SATURATE_EN
  output logic [CNT_WIDTH-1:0] blocks_done,
  output logic                 acc_sat
`else
  output logic [CNT_WIDTH-1:0] blocks_done
`endif
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Sample count of the last word in a block.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN - 1);

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc, acc_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic [ACC_WIDTH-1:0]   acc_out_nxt;
  logic                   acc_valid_nxt;
  logic                   sum_ready_nxt;
  logic [CNT_WIDTH-1:0]   blocks_done_nxt;
  logic [ACC_WIDTH-1:0]   add_res;
  logic                   in_xfer;
  logic                   out_xfer;

  assign in_xfer  = sum_valid & sum_ready;
  assign out_xfer = acc_valid & acc_ready;

`ifdef ACC_SATURATE_EN
  logic                   sat_flag, sat_flag_nxt;
  logic                   acc_sat_nxt;
  logic                   sat_hit;
  logic [ACC_WIDTH:0]     add_wide;

  // One extra bit catches the carry-out; a carry pins the result to all-ones.
  assign add_wide = {1'b0, acc} + {{(ACC_WIDTH + 1 - SUM_WIDTH){1'b0}}, sum_in};
  assign sat_hit  = add_wide[ACC_WIDTH];
  assign add_res  = sat_hit ? {ACC_WIDTH{1'b1}} : add_wide[ACC_WIDTH-1:0];
`else
  // Plain modulo-2^ACC_WIDTH addition of the zero-extended sum word.
  assign add_res = acc + {{(ACC_WIDTH - SUM_WIDTH){1'b0}}, sum_in};
`endif

  // Next-state and datapath decode; every target is defaulted to "hold" first.
  always_comb begin
    state_nxt       = state;
    acc_nxt         = acc;
    cnt_nxt         = cnt;
    acc_out_nxt     = acc_out;
    acc_valid_nxt   = acc_valid;
    sum_ready_nxt   = sum_ready;
    blocks_done_nxt = blocks_done;
`ifdef ACC_SATURATE_EN
    sat_flag_nxt    = sat_flag;
    acc_sat_nxt     = acc_sat;
`endif

    case (state)
      ACCUM: begin
        // sum_ready comes up one edge after reset release and stays high here.
        sum_ready_nxt = 1'b1;
        if (in_xfer) begin
          acc_nxt = add_res;
          cnt_nxt = cnt + CNT_WIDTH'(1);
`ifdef ACC_SATURATE_EN
          sat_flag_nxt = sat_flag | sat_hit;
`endif
          if (cnt == LAST_CNT) begin
            // Last sample of the block: publish the total.
            // Clear the running state so the next block starts clean.
            acc_out_nxt   = add_res;
            acc_valid_nxt = 1'b1;
            sum_ready_nxt = 1'b0;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            state_nxt     = HOLD;
`ifdef ACC_SATURATE_EN
            acc_sat_nxt   = sat_flag | sat_hit;
            sat_flag_nxt  = 1'b0;
`endif
          end
        end
      end

      HOLD: begin
        // Input is stalled; any sum_valid here is simply not accepted.
        sum_ready_nxt = 1'b0;
        acc_valid_nxt = 1'b1;
        if (out_xfer) begin
          acc_valid_nxt   = 1'b0;
          sum_ready_nxt   = 1'b1;
          blocks_done_nxt = blocks_done + CNT_WIDTH'(1);
          state_nxt       = ACCUM;
        end
      end

      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      acc_out     <= '0;
      acc_valid   <= 1'b0;
      sum_ready   <= 1'b0;
      blocks_done <= '0;
`ifdef ACC_SATURATE_EN
      sat_flag    <= 1'b0;
      acc_sat     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      acc_out     <= acc_out_nxt;
      acc_valid   <= acc_valid_nxt;
      sum_ready   <= sum_ready_nxt;
      blocks_done <= blocks_done_nxt;
`ifdef ACC_SATURATE_EN
      sat_flag    <= sat_flag_nxt;
      acc_sat     <= acc_sat_nxt;
`endif
    end
  end

endmodule
